// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
//
// Circular FIFO of free physical register indices for the rename stage.
// The head entry is offered to the RAT (first-word-fall-through); the ROB
// returns the previous mapping of a committed destination at the tail.
// A mispredict flush returns every speculatively allocated register in one
// cycle by moving head to sit one full lap behind tail.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   rst              : synchronous active-low reset (0 = reset)
//   flush            : mispredict recovery strobe
//   alloc_en         : dispatch consumes the head entry this cycle
//   free_valid       : head entry is available (FIFO not empty)
//   free_preg        : head entry, to the RAT pd_dispatch port
//   commit_free_en   : ROB commit returns a physical register
//   commit_free_preg : physical register being returned (0 is never queued)
//   free_count       : number of entries held, 0..D
//   overflow_err     : sticky flag, set on an enqueue attempted while full
//
// Handshake: a dequeue happens on an edge where alloc_en=1 and free_valid=1
// (and flush=0); free_preg is the value consumed. An enqueue happens on an
// edge where commit_free_en=1 and commit_free_preg!=0, provided the list is
// not full or a dequeue happens on the same edge.
// ---------------------------------------------------------------------------
module free_list #(
    parameter int P_REG_NUM    = 64,
    parameter int ARCH_REG_NUM = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic                                      alloc_en,
    output logic                                      free_valid,
    output logic [$clog2(P_REG_NUM)-1:0]              free_preg,
    input  logic                                      commit_free_en,
    input  logic [$clog2(P_REG_NUM)-1:0]              commit_free_preg,
    output logic [$clog2(P_REG_NUM-ARCH_REG_NUM):0]   free_count,
    output logic                                      overflow_err
);

    localparam int D  = P_REG_NUM - ARCH_REG_NUM;
    localparam int PW = $clog2(P_REG_NUM);
    localparam int IW = $clog2(D);
    localparam int CW = IW + 1;

    logic [PW-1:0] entry_q [D];
    logic [PW-1:0] entry_d [D];
    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] tail_q, tail_d;
    logic          overflow_q, overflow_d;

    logic          empty;
    logic          full;
    logic          enq_req;
    logic          deq;
    logic          enq;

    // Advance a pointer: index wraps from D-1 to 0 and the phase bit toggles.
    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        logic [CW-1:0] r;
        if (p[IW-1:0] == IW'(D - 1)) begin
            r = {~p[IW], {IW{1'b0}}};
        end else begin
            r = p + CW'(1);
        end
        return r;
    endfunction

    always_comb begin
        empty = (head_q == tail_q);
        full  = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);

        // Same phase: plain difference. Different phase: tail is one lap ahead.
        if (head_q[IW] == tail_q[IW]) begin
            free_count = {1'b0, tail_q[IW-1:0]} - {1'b0, head_q[IW-1:0]};
        end else begin
            free_count = CW'(D) + {1'b0, tail_q[IW-1:0]} - {1'b0, head_q[IW-1:0]};
        end

        free_valid   = !empty;
        free_preg    = entry_q[head_q[IW-1:0]];
        overflow_err = overflow_q;
    end

    always_comb begin
        enq_req = commit_free_en && (commit_free_preg != '0);
        deq     = alloc_en && !empty && !flush;
        // When full, an enqueue is only legal if the head slot frees this edge.
        enq     = enq_req && (!full || deq);

        entry_d = entry_q;
        if (enq) begin
            entry_d[tail_q[IW-1:0]] = commit_free_preg;
        end

        tail_d = enq ? ptr_inc(tail_q) : tail_q;

        // Flush: slots dequeued since the last commit still hold their
        // indices, so placing head one lap behind tail returns exactly the
        // speculative allocations.
        if (flush) begin
            head_d = {~tail_d[IW], tail_d[IW-1:0]};
        end else if (deq) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end

        overflow_d = overflow_q | (enq_req && full && !deq);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < D; i++) begin
                entry_q[i] <= PW'(ARCH_REG_NUM + i);
            end
            head_q     <= '0;
            tail_q     <= {1'b1, {IW{1'b0}}};
            overflow_q <= 1'b0;
        end else begin
            entry_q    <= entry_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list : self-checking bench for free_list (P_REG_NUM=64, ARCH=32).
// ---------------------------------------------------------------------------
module tb_free_list;

    localparam int D = 32;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       alloc_en;
    logic       free_valid;
    logic [5:0] free_preg;
    logic       commit_free_en;
    logic [5:0] commit_free_preg;
    logic [5:0] free_count;
    logic       overflow_err;

    int tests_run = 0;
    int fails     = 0;

    logic [5:0] exp_q[$];

    // Reference state for the random test
    int m_mem [D];
    int m_head;
    int m_tail;
    int retire_map [32];
    int rob_rd[$];
    int rob_pd[$];

    free_list #(.P_REG_NUM(64), .ARCH_REG_NUM(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .alloc_en         (alloc_en),
        .free_valid       (free_valid),
        .free_preg        (free_preg),
        .commit_free_en   (commit_free_en),
        .commit_free_preg (commit_free_preg),
        .free_count       (free_count),
        .overflow_err     (overflow_err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush            = 1'b0;
        alloc_en         = 1'b0;
        commit_free_en   = 1'b0;
        commit_free_preg = 6'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        do_reset();
        tests_run++;
        if (free_valid !== 1'b1) begin fails++; $display("FAIL reset_valid: got %0b want 1", free_valid); end
        tests_run++;
        if (free_preg !== 6'd32) begin fails++; $display("FAIL reset_preg: got %0d want 32", free_preg); end
        tests_run++;
        if (free_count !== 6'd32) begin fails++; $display("FAIL reset_count: got %0d want 32", free_count); end
        tests_run++;
        if (overflow_err !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b want 0", overflow_err); end
    endtask

    task automatic test_drain();
        logic [5:0] e;
        for (int i = 32; i < 64; i++) exp_q.push_back(6'(i));
        while (exp_q.size() > 0) begin
            alloc_en = 1'b1;
            e = exp_q.pop_front();
            tests_run++;
            if (free_valid !== 1'b1 || free_preg !== e) begin
                fails++;
                $display("FAIL drain_preg: got valid=%0b preg=%0d want valid=1 preg=%0d", free_valid, free_preg, e);
            end
            tick();
        end
        alloc_en = 1'b0;
        tests_run++;
        if (free_valid !== 1'b0) begin fails++; $display("FAIL drain_empty_valid: got %0b want 0", free_valid); end
        tests_run++;
        if (free_count !== 6'd0) begin fails++; $display("FAIL drain_empty_count: got %0d want 0", free_count); end
        alloc_en = 1'b1;
        tick();
        alloc_en = 1'b0;
        tests_run++;
        if (free_count !== 6'd0) begin fails++; $display("FAIL drain_extra_count: got %0d want 0", free_count); end
        tests_run++;
        if (overflow_err !== 1'b0) begin fails++; $display("FAIL drain_extra_ovf: got %0b want 0", overflow_err); end
    endtask

    task automatic test_commit_empty();
        commit_free_en   = 1'b1;
        commit_free_preg = 6'd40;
        alloc_en         = 1'b1;
        #1;
        tests_run++;
        if (free_valid !== 1'b0) begin fails++; $display("FAIL empty_no_bypass: got valid %0b want 0", free_valid); end
        tick();
        idle_inputs();
        tests_run++;
        if (free_valid !== 1'b1) begin fails++; $display("FAIL empty_commit_valid: got %0b want 1", free_valid); end
        tests_run++;
        if (free_preg !== 6'd40) begin fails++; $display("FAIL empty_commit_preg: got %0d want 40", free_preg); end
        tests_run++;
        if (free_count !== 6'd1) begin fails++; $display("FAIL empty_commit_count: got %0d want 1", free_count); end
        commit_free_en   = 1'b1;
        commit_free_preg = 6'd0;
        tick();
        idle_inputs();
        tests_run++;
        if (free_count !== 6'd1) begin fails++; $display("FAIL commit_zero_count: got %0d want 1", free_count); end
    endtask

    task automatic test_flush();
        logic [5:0] e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            alloc_en = 1'b1;
            tests_run++;
            if (free_preg !== 6'(32 + k)) begin fails++; $display("FAIL flush_alloc: got %0d want %0d", free_preg, 32 + k); end
            tick();
        end
        // Fifth allocation (36) with commit of 7 on the same edge
        alloc_en         = 1'b1;
        commit_free_en   = 1'b1;
        commit_free_preg = 6'd7;
        tests_run++;
        if (free_preg !== 6'd36) begin fails++; $display("FAIL flush_alloc5: got %0d want 36", free_preg); end
        tick();
        idle_inputs();
        flush    = 1'b1;
        alloc_en = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (free_count !== 6'd32) begin fails++; $display("FAIL flush_count: got %0d want 32", free_count); end
        tests_run++;
        if (overflow_err !== 1'b0) begin fails++; $display("FAIL flush_ovf: got %0b want 0", overflow_err); end
        // Slot 0 now holds 7; slots 1..31 still hold 33..63.
        for (int i = 33; i < 64; i++) exp_q.push_back(6'(i));
        exp_q.push_back(6'd7);
        while (exp_q.size() > 0) begin
            alloc_en = 1'b1;
            e = exp_q.pop_front();
            tests_run++;
            if (free_valid !== 1'b1 || free_preg !== e) begin
                fails++;
                $display("FAIL flush_seq: got valid=%0b preg=%0d want valid=1 preg=%0d", free_valid, free_preg, e);
            end
            tick();
        end
        alloc_en = 1'b0;
        tests_run++;
        if (free_count !== 6'd0) begin fails++; $display("FAIL flush_drained: got %0d want 0", free_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        commit_free_en   = 1'b1;
        commit_free_preg = 6'd50;
        tick();
        idle_inputs();
        tests_run++;
        if (free_count !== 6'd32) begin fails++; $display("FAIL ovf_count: got %0d want 32", free_count); end
        tests_run++;
        if (overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_set: got %0b want 1", overflow_err); end
        alloc_en = 1'b1;
        tick(); tick(); tick();
        alloc_en = 1'b0;
        tests_run++;
        if (overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %0b want 1", overflow_err); end
        tests_run++;
        if (free_count !== 6'd29) begin fails++; $display("FAIL ovf_alloc_count: got %0d want 29", free_count); end
        do_reset();
        tests_run++;
        if (overflow_err !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got %0b want 0", overflow_err); end
        // Full with simultaneous dequeue: legal, not an overflow
        alloc_en         = 1'b1;
        commit_free_en   = 1'b1;
        commit_free_preg = 6'd50;
        tick();
        idle_inputs();
        tests_run++;
        if (free_count !== 6'd32) begin fails++; $display("FAIL full_deq_enq_count: got %0d want 32", free_count); end
        tests_run++;
        if (overflow_err !== 1'b0) begin fails++; $display("FAIL full_deq_enq_ovf: got %0b want 0", overflow_err); end
        tests_run++;
        if (free_preg !== 6'd33) begin fails++; $display("FAIL full_deq_enq_head: got %0d want 33", free_preg); end
    endtask

    function automatic bit in_use(input int v);
        for (int r = 0; r < 32; r++) if (retire_map[r] == v) return 1'b1;
        foreach (rob_pd[j]) if (rob_pd[j] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = 32 + i;
        m_head = 0;
        m_tail = D;
        for (int r = 0; r < 32; r++) retire_map[r] = r;
        rob_rd.delete();
        rob_pd.delete();
    endtask

    task automatic test_random();
        int  cnt, exp_preg, rd, old, pd;
        bit  a, c, f, deq, enq;
        do_reset();
        model_reset();
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                rst              = 1'b0;
                alloc_en         = 1'b1;
                commit_free_en   = 1'b1;
                commit_free_preg = 6'($urandom_range(1, 63));
                flush            = 1'($urandom_range(0, 1));
                tick();
                rst = 1'b1;
                idle_inputs();
                model_reset();
                tests_run++;
                if (free_valid !== 1'b1 || free_preg !== 6'd32 || free_count !== 6'd32 || overflow_err !== 1'b0) begin
                    fails++;
                    $display("FAIL midrun_reset: got valid=%0b preg=%0d count=%0d ovf=%0b want 1/32/32/0",
                             free_valid, free_preg, free_count, overflow_err);
                end
                continue;
            end
            a   = ($urandom_range(0, 99) < 60);
            c   = (rob_rd.size() > 0) && ($urandom_range(0, 99) < 50);
            f   = ($urandom_range(0, 99) < 3);
            old = 0;
            if (c) begin
                old = retire_map[rob_rd[0]];
                commit_free_en   = 1'b1;
                commit_free_preg = 6'(old);
            end else if ($urandom_range(0, 99) < 5) begin
                commit_free_en   = 1'b1;
                commit_free_preg = 6'd0;
            end else begin
                commit_free_en   = 1'b0;
                commit_free_preg = 6'($urandom_range(0, 63));
            end
            alloc_en = a;
            flush    = f;

            cnt      = (m_tail - m_head + 2 * D) % (2 * D);
            exp_preg = m_mem[m_head % D];
            tests_run++;
            if (free_count !== 6'(cnt)) begin fails++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", i, free_count, cnt); end
            tests_run++;
            if (free_valid !== (cnt != 0)) begin fails++; $display("FAIL rnd_valid cyc %0d: got %0b want %0b", i, free_valid, cnt != 0); end
            tests_run++;
            if (overflow_err !== 1'b0) begin fails++; $display("FAIL rnd_ovf cyc %0d: got %0b want 0", i, overflow_err); end
            if (cnt != 0) begin
                exp_q.push_back(6'(exp_preg));
                tests_run++;
                if (free_preg !== exp_q[0]) begin fails++; $display("FAIL rnd_preg cyc %0d: got %0d want %0d", i, free_preg, exp_q[0]); end
                void'(exp_q.pop_front());
                tests_run++;
                if (in_use(int'(free_preg))) begin fails++; $display("FAIL rnd_dup cyc %0d: preg %0d offered while in use, want unused", i, free_preg); end
            end

            // Reference update
            deq = a && (cnt != 0) && !f;
            enq = c && (old != 0);
            if (enq) begin
                m_mem[m_tail % D] = old;
                m_tail = (m_tail + 1) % (2 * D);
            end
            if (f) m_head = (m_tail + D) % (2 * D);
            else if (deq) m_head = (m_head + 1) % (2 * D);

            if (c) begin
                rd = rob_rd.pop_front();
                pd = rob_pd.pop_front();
                retire_map[rd] = pd;
            end
            if (deq) begin
                rob_rd.push_back($urandom_range(1, 31));
                rob_pd.push_back(exp_preg);
            end
            if (f) begin
                rob_rd.delete();
                rob_pd.delete();
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_drain();
        test_commit_empty();
        test_flush();
        test_overflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
